// File: rtl/snake_step_engine.sv
// Snake move engine: turns each frame tick into erase-tail / advance-head / draw-head
// pixel traffic for the VGA adapter, with wrap-around and sticky self-collision.
module snake_step_engine #(
  parameter int          LEN          = 8,
  parameter int          START_GX     = 20,
  parameter int          START_GY     = 15,
  parameter logic [2:0]  SNAKE_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [1:0] dir_req,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       collision,
  output logic [5:0] head_gx,
  output logic [4:0] head_gy
);

  localparam int unsigned NSEG = LEN;

  typedef enum logic [2:0] {INIT, IDLE, ERASE, MOVE, DRAW, HALT} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] idx;
  logic [1:0] dir;
  logic [5:0] seg_gx [NSEG];
  logic [4:0] seg_gy [NSEG];

  logic [3:0] cnt_nx;
  logic [5:0] sel_gx, nh_gx;
  logic [4:0] sel_gy, nh_gy;
  logic       hit;

  assign cnt_nx  = cnt + 4'd1;
  assign head_gx = seg_gx[0];
  assign head_gy = seg_gy[0];

  // Segment picked by the INIT walk; a compare loop avoids an oversized array index.
  always_comb begin
    sel_gx = '0;
    sel_gy = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (idx == 5'(i)) begin
        sel_gx = seg_gx[i];
        sel_gy = seg_gy[i];
      end
    end
  end

  always_comb begin
    nh_gx = seg_gx[0];
    nh_gy = seg_gy[0];
    case (dir)
      2'b00:   nh_gx = (seg_gx[0] == 6'd39) ? '0 : seg_gx[0] + 6'd1;
      2'b01:   nh_gx = (seg_gx[0] == '0) ? 6'd39 : seg_gx[0] - 6'd1;
      2'b10:   nh_gy = (seg_gy[0] == '0) ? 5'd29 : seg_gy[0] - 5'd1;
      default: nh_gy = (seg_gy[0] == 5'd29) ? '0 : seg_gy[0] + 5'd1;
    endcase
  end

  // The tail cell is vacated by this move, so it is left out of the check.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i + 1 < NSEG; i++) begin
      if (seg_gx[i] == nh_gx && seg_gy[i] == nh_gy) hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= INIT;
      cnt       <= '0;
      idx       <= '0;
      dir       <= 2'b00;
      plot      <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      busy      <= 1'b1;
      collision <= 1'b0;
      for (int unsigned i = 0; i < NSEG; i++) begin
        seg_gx[i] <= 6'((START_GX + 40 - int'(i)) % 40);
        seg_gy[i] <= 5'(START_GY);
      end
    end else begin
      case (state)
        INIT: begin
          if (idx == 5'(LEN)) begin
            state <= IDLE;
            plot  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            plot   <= 1'b1;
            x      <= {sel_gx, cnt[1:0]};
            y      <= {sel_gy, cnt[3:2]};
            colour <= SNAKE_COLOUR;
            cnt    <= cnt_nx;
            if (cnt == 4'd15) idx <= idx + 5'd1;
          end
        end
        IDLE: begin
          plot <= 1'b0;
          if (tick) begin
            if (!(dir_req[1] == dir[1] && dir_req[0] != dir[0])) dir <= dir_req;
            state  <= ERASE;
            busy   <= 1'b1;
            cnt    <= '0;
            plot   <= 1'b1;
            x      <= {seg_gx[NSEG-1], 2'b00};
            y      <= {seg_gy[NSEG-1], 2'b00};
            colour <= BG_COLOUR;
          end
        end
        ERASE: begin
          if (cnt == 4'd15) begin
            state <= MOVE;
            plot  <= 1'b0;
          end else begin
            cnt  <= cnt_nx;
            plot <= 1'b1;
            x    <= {seg_gx[NSEG-1], cnt_nx[1:0]};
            y    <= {seg_gy[NSEG-1], cnt_nx[3:2]};
          end
        end
        MOVE: begin
          if (hit) begin
            collision <= 1'b1;
            state     <= HALT;
            plot      <= 1'b0;
          end else begin
            for (int unsigned i = 1; i < NSEG; i++) begin
              seg_gx[i] <= seg_gx[i-1];
              seg_gy[i] <= seg_gy[i-1];
            end
            seg_gx[0] <= nh_gx;
            seg_gy[0] <= nh_gy;
            state     <= DRAW;
            cnt       <= '0;
            plot      <= 1'b1;
            x         <= {nh_gx, 2'b00};
            y         <= {nh_gy, 2'b00};
            colour    <= SNAKE_COLOUR;
          end
        end
        DRAW: begin
          if (cnt == 4'd15) begin
            state <= IDLE;
            plot  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt_nx;
            plot <= 1'b1;
            x    <= {seg_gx[0], cnt_nx[1:0]};
            y    <= {seg_gy[0], cnt_nx[3:2]};
          end
        end
        HALT: begin
          plot <= 1'b0;
          busy <= 1'b1;
        end
        default: begin
          state <= INIT;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_engine.sv
// Bench for snake_step_engine: a snake-as-queue model predicts every output cycle,
// plus directed scenarios with literal expectations.
module tb_snake_step_engine;

  localparam int         LEN   = 8;
  localparam int         SGX   = 20;
  localparam int         SGY   = 15;
  localparam logic [2:0] SNAKE = 3'b010;
  localparam logic [2:0] BG    = 3'b000;

  logic       clk = 1'b0;
  logic       resetn, tick;
  logic [1:0] dir_req;
  logic       plot, busy, collision;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic [5:0] head_gx;
  logic [4:0] head_gy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snake_step_engine #(
    .LEN(LEN), .START_GX(SGX), .START_GY(SGY),
    .SNAKE_COLOUR(SNAKE), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .dir_req(dir_req),
    .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy),
    .collision(collision), .head_gx(head_gx), .head_gy(head_gy)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       busy;
    logic       coll;
    logic [5:0] hx;
    logic [4:0] hy;
  } obs_t;

  obs_t q[$];
  obs_t cur;
  int   sx[$], sy[$];
  int   mdir;
  bit   halted;
  bit   mvalid = 1'b0;

  function automatic obs_t pix(int gx, int gy, int k, logic [2:0] c, int hx, int hy);
    obs_t o;
    o.plot = 1'b1;
    o.x    = 8'(gx * 4 + k % 4);
    o.y    = 7'(gy * 4 + k / 4);
    o.col  = c;
    o.busy = 1'b1;
    o.coll = 1'b0;
    o.hx   = 6'(hx);
    o.hy   = 5'(hy);
    return o;
  endfunction

  function automatic obs_t quiet(logic b, logic c, int hx, int hy);
    obs_t o;
    o = '0;
    o.busy = b;
    o.coll = c;
    o.hx   = 6'(hx);
    o.hy   = 5'(hy);
    return o;
  endfunction

  task automatic m_reset();
    q.delete();
    sx.delete();
    sy.delete();
    for (int i = 0; i < LEN; i++) begin
      sx.push_back((SGX - i + 40) % 40);
      sy.push_back(SGY);
    end
    mdir   = 0;
    halted = 1'b0;
    for (int i = 0; i < LEN; i++)
      for (int k = 0; k < 16; k++) q.push_back(pix(sx[i], sy[i], k, SNAKE, SGX, SGY));
  endtask

  task automatic m_accept(int d);
    int  ohx, ohy, nx, ny;
    bit  rev, hitm;
    rev = (mdir == 0 && d == 1) || (mdir == 1 && d == 0) ||
          (mdir == 2 && d == 3) || (mdir == 3 && d == 2);
    if (!rev) mdir = d;
    ohx = sx[0];
    ohy = sy[0];
    nx  = ohx;
    ny  = ohy;
    case (mdir)
      0: nx = (ohx + 1) % 40;
      1: nx = (ohx + 39) % 40;
      2: ny = (ohy + 29) % 30;
      default: ny = (ohy + 1) % 30;
    endcase
    for (int k = 0; k < 16; k++) q.push_back(pix(sx[LEN-1], sy[LEN-1], k, BG, ohx, ohy));
    q.push_back(quiet(1'b1, 1'b0, ohx, ohy));
    hitm = 1'b0;
    for (int i = 0; i < LEN - 1; i++) if (sx[i] == nx && sy[i] == ny) hitm = 1'b1;
    if (hitm) begin
      halted = 1'b1;
    end else begin
      sx.push_front(nx);
      sy.push_front(ny);
      void'(sx.pop_back());
      void'(sy.pop_back());
      for (int k = 0; k < 16; k++) q.push_back(pix(nx, ny, k, SNAKE, nx, ny));
    end
  endtask

  // Model state describes the outputs visible after this edge.
  always @(posedge clk) begin
    if (!resetn) begin
      m_reset();
      cur = quiet(1'b1, 1'b0, SGX, SGY);
    end else begin
      if (q.size() == 0 && !halted && !cur.busy && tick) m_accept(int'(dir_req));
      if (q.size() > 0) cur = q.pop_front();
      else              cur = quiet(halted, halted, sx[0], sy[0]);
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    obs_t a, e;
    if (mvalid) begin
      a = {plot, x, y, colour, busy, collision, head_gx, head_gy};
      e = cur;
      if (!e.plot) begin
        a.x = '0; a.y = '0; a.col = '0;
        e.x = '0; e.y = '0; e.col = '0;
      end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL stream t=%0t got plot=%b x=%0d y=%0d col=%0d busy=%b coll=%b head=(%0d,%0d) want plot=%b x=%0d y=%0d col=%0d busy=%b coll=%b head=(%0d,%0d)",
                 $time, a.plot, a.x, a.y, a.col, a.busy, a.coll, a.hx, a.hy,
                 e.plot, e.x, e.y, e.col, e.busy, e.coll, e.hx, e.hy);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_move(input logic [1:0] d, output int bc, output int np, output int nd,
                         output int fex, output int fey, output int fec,
                         output int fdx, output int fdy);
    bit se, sd;
    @(negedge clk);
    tick    = 1'b1;
    dir_req = d;
    @(negedge clk);
    tick = 1'b0;
    bc = 0; np = 0; nd = 0;
    fex = -1; fey = -1; fec = -1; fdx = -1; fdy = -1;
    se = 1'b0; sd = 1'b0;
    while (busy && bc < 60) begin
      bc++;
      if (plot) begin
        np++;
        if (!se) begin fex = x; fey = y; fec = colour; se = 1'b1; end
        if (colour == SNAKE) begin
          nd++;
          if (!sd) begin fdx = x; fdy = y; sd = 1'b1; end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_init(output int cyc, output int npx, output int lx, output int ly);
    cyc = 0; npx = 0; lx = -1; ly = -1;
    while (busy && cyc < 300) begin
      cyc++;
      if (plot) begin npx++; lx = x; ly = y; end
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, np, nd, fex, fey, fec, fdx, fdy, cyc, npx, lx, ly;
    resetn  = 1'b0;
    tick    = 1'b0;
    dir_req = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 1);
    chk("rst_collision", collision, 0);
    chk("rst_head_gx", head_gx, 20);
    chk("rst_head_gy", head_gy, 15);
    chk("rst_x", x, 0);
    chk("rst_colour", colour, 0);

    resetn = 1'b1;
    @(negedge clk);
    chk("init_first_x", x, 80);
    chk("init_first_y", y, 60);
    chk("init_first_colour", colour, 2);
    wait_init(cyc, npx, lx, ly);
    chk("init_busy_cycles", cyc, 128);
    chk("init_pixels", npx, 128);
    chk("init_last_x", lx, 55);
    chk("init_last_y", ly, 63);
    chk("init_head_gx", head_gx, 20);

    do_move(2'b00, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("move_busy_cycles", bc, 33);
    chk("move_pixels", np, 32);
    chk("move_draw_pixels", nd, 16);
    chk("erase_x", fex, 52);
    chk("erase_y", fey, 60);
    chk("erase_colour", fec, 0);
    chk("draw_x", fdx, 84);
    chk("draw_y", fdy, 60);
    chk("move_head_gx", head_gx, 21);

    for (int i = 0; i < 18; i++) do_move(2'b00, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("edge_head_gx", head_gx, 39);
    do_move(2'b00, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("wrap_head_gx", head_gx, 0);
    chk("wrap_draw_x", fdx, 0);

    do_move(2'b01, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("reversal_head_gx", head_gx, 1);
    do_move(2'b10, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("up_head_gy", head_gy, 14);
    chk("up_head_gx", head_gx, 1);

    // Second tick during a move must not queue another move.
    @(negedge clk);
    tick = 1'b1; dir_req = 2'b00;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc = 0;
    while (busy && cyc < 60) begin cyc++; @(negedge clk); end
    repeat (3) @(negedge clk);
    chk("extra_tick_busy", busy, 0);
    chk("extra_tick_head_gx", head_gx, 2);

    // Reset mid-move aborts and restarts INIT.
    @(negedge clk);
    tick = 1'b1; dir_req = 2'b00;
    @(negedge clk);
    tick = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 1);
    chk("abort_head_gx", head_gx, 20);
    resetn = 1'b1;
    @(negedge clk);
    chk("reinit_first_x", x, 80);
    chk("reinit_first_y", y, 60);
    wait_init(cyc, npx, lx, ly);
    chk("reinit_pixels", npx, 128);

    // Right, down, left, up closes a loop onto seg[3].
    do_move(2'b00, bc, np, nd, fex, fey, fec, fdx, fdy);
    do_move(2'b11, bc, np, nd, fex, fey, fec, fdx, fdy);
    do_move(2'b01, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("loop_head_gx", head_gx, 20);
    chk("loop_head_gy", head_gy, 16);
    do_move(2'b10, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("hit_collision", collision, 1);
    chk("hit_busy_held", bc, 60);
    chk("hit_pixels", np, 16);
    chk("hit_draw_pixels", nd, 0);
    chk("hit_head_gy", head_gy, 16);
    do_move(2'b00, bc, np, nd, fex, fey, fec, fdx, fdy);
    chk("halt_pixels", np, 0);
    chk("halt_collision", collision, 1);
    chk("halt_head_gx", head_gx, 20);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_step_engine.md
# snake_step_engine

Consumer end of the game-timing chain: takes the one-cycle frame tick produced by the rate divider and frame counter, and turns each tick into one snake move. It erases the tail block, advances the head one grid cell in the latched direction with edge wrap-around, detects self-collision, and draws the new head. The pixel stream (`x`, `y`, `colour`, `plot`) drives the VGA adapter write port directly, one pixel per cycle.

## Interface
- `LEN`, 8: snake length in segments, 2..16.
- `START_GX`, 20: head grid column at reset, 0..39.
- `START_GY`, 15: head grid row at reset, 0..29.
- `SNAKE_COLOUR`, 3'b010: colour for drawn blocks.
- `BG_COLOUR`, 3'b000: colour for erased blocks.
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-cycle move request from the frame counter.
- `dir_req`  in  2  requested direction: 00 right, 01 left, 10 up, 11 down.
- `plot`  out  1  pixel write strobe to the VGA adapter.
- `x`  out  8  pixel column, 0..159.
- `y`  out  7  pixel row, 0..119.
- `colour`  out  3  pixel colour.
- `busy`  out  1  high whenever state ≠ IDLE.
- `collision`  out  1  sticky; set on self-hit.
- `head_gx`  out  6  current head column.
- `head_gy`  out  5  current head row.

## Operation
- Grid is 40×30 cells. Each cell is a 4×4 pixel block. Pixel x = {gx,2'b00}+cnt[1:0]; pixel y = {gy,2'b00}+cnt[3:2]. `cnt` is a 4-bit pixel counter, so pixels go out in row-major order.
- Body register file holds seg[0..LEN-1] (seg[0] = head). At reset, seg[i] = (START_GX−i mod 40, START_GY) and dir = right.
- States and transitions:
  - INIT: draws seg[0..LEN-1] in index order, 16 pixels each, SNAKE_COLOUR. Then goes to IDLE.
  - IDLE: `busy` = 0. On `tick`=1, latches `dir_req` into dir, except a direct reversal (right↔left, up↔down), which is ignored and dir is kept. Then goes to ERASE.
  - ERASE: 16 cycles plotting seg[LEN-1] in BG_COLOUR.
  - MOVE: one cycle, `plot`=0.
    - Computes the new head from seg[0] and dir. gx wraps 39→0 and 0→39; gy wraps 29→0 and 0→29.
    - If the new head equals any of seg[0..LEN-2]: set `collision`, leave the body unchanged, go to HALT.
    - Otherwise shift seg[i] ← seg[i−1] and set seg[0] ← new head, then go to DRAW.
  - DRAW: 16 cycles plotting the new seg[0] in SNAKE_COLOUR, then IDLE.
  - HALT: terminal. `busy`=1 and `plot`=0; ticks are ignored. Exit only by reset.
- `tick` is ignored in every state except IDLE. It is not queued.
- `dir_req` is sampled only in the IDLE cycle where `tick`=1.
- The tail cell vacated this move is excluded from the collision check, so chasing the tail is legal.

## Timing
- While `resetn`=0 at an edge:
  - state ← INIT, cnt ← 0, `plot` ← 0, `x` ← 0, `y` ← 0, `colour` ← 0.
  - `busy` ← 1, `collision` ← 0.
  - `head_gx` ← START_GX, `head_gy` ← START_GY.
- Reset asserted mid-operation aborts immediately. Partially drawn pixels are not cleaned up.
- All outputs are registered. `x`/`y`/`colour` are valid in every cycle where `plot`=1.
- INIT takes LEN×16 cycles. With LEN=8, `busy` falls 128 cycles after the first edge with `resetn`=1.
- For a `tick` sampled at edge T:
  - ERASE pixels occupy cycles T+1..T+16.
  - MOVE is T+17. `head_gx`/`head_gy` update at the end of MOVE.
  - DRAW pixels occupy T+18..T+33.
  - `busy` = 0 from T+34.
  - Total: 33 busy cycles per move.
- On collision, `collision` rises at T+18 and `plot` stays 0 from T+17 on.
- `tick` asserted in the same cycle that DRAW ends is ignored. It is accepted only once `busy`=0.

## Test plan
- Reset with LEN=8, START=(20,15): 128 plot cycles. First pixel is (80,60); last block is seg[7]=(13,15), pixels x 52..55, y 60..63. Then `busy`=0, `head_gx`=20.
- One tick, dir_req=00: 16 pixels at x 52..55 y 60..63 with colour 0, one idle cycle, 16 pixels at x 84..87 y 60..63 with colour 2. `head_gx`=21. `busy` is high for exactly 33 cycles.
- Head at gx=39 moving right, tick: new head is gx=0, and DRAW pixels are at x 0..3.
- Heading right, dir_req=01 (reversal) with tick: head moves right to gx+1. Next dir_req=10 gives gy−1.
- Steer right, down, left, up on consecutive ticks with LEN=8: the fourth move hits seg[3]. `collision`=1, no DRAW pixels, and all later ticks are ignored until reset.
- `tick` pulsed at T+5 during a move: no extra move. Assert `resetn`=0 at T+10: `plot`=0 on the next edge, then INIT restarts.
